// File: rtl/game_controller.sv
// Round sequencer for the memory game: shows an LFSR-derived 4-digit BCD target,
// collects four user digits and registers a match verdict plus a saturating streak.
module game_controller #(
    parameter int          SHOW_TICKS   = 3,
    parameter int          RESULT_TICKS = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        startBtn,
    input  logic        enterBtn,
    input  logic        clearBtn,
    input  logic [3:0]  digitSw,
    output logic        displayPhase,
    output logic [15:0] randInt,
    output logic [15:0] userInput,
    output logic        inputReady,
    output logic        correct,
    output logic [7:0]  streak
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        ENTRY  = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam logic [7:0] SHOW_LAST   = 8'(SHOW_TICKS - 1);
    localparam logic [7:0] RESULT_LAST = 8'(RESULT_TICKS - 1);

    state_t      state_r;
    logic [15:0] lfsr_r;
    logic [7:0]  tick_cnt_r;
    logic [2:0]  digit_cnt_r;
    logic        display_phase_r;
    logic        input_ready_r;
    logic        correct_r;
    logic [15:0] rand_int_r;
    logic [15:0] user_input_r;
    logic [7:0]  streak_r;

    logic        lfsr_fb_s;
    logic        digit_ok_s;
    logic [15:0] next_digits_s;
    logic        match_s;

    function automatic logic [3:0] bcd_nib(input logic [3:0] n);
        if (n <= 4'd9) begin
            return n;
        end else begin
            return n - 4'd6;
        end
    endfunction

    function automatic logic [15:0] bcd_map(input logic [15:0] v);
        return {bcd_nib(v[15:12]), bcd_nib(v[11:8]), bcd_nib(v[7:4]), bcd_nib(v[3:0])};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Decode of the shift-in digit and the match against the target.
    always_comb begin
        lfsr_fb_s     = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
        digit_ok_s    = (digitSw <= 4'd9);
        next_digits_s = {user_input_r[11:0], digitSw};
        match_s       = (next_digits_s == rand_int_r);
    end

    // Free-running LFSR; a nonzero seed keeps it out of the all-zero lockup.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
        end
    end

    // Round FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= IDLE;
            tick_cnt_r      <= 8'd0;
            digit_cnt_r     <= 3'd0;
            display_phase_r <= 1'b0;
            input_ready_r   <= 1'b0;
            correct_r       <= 1'b0;
            rand_int_r      <= 16'd0;
            user_input_r    <= 16'd0;
            streak_r        <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (startBtn) begin
                        rand_int_r      <= bcd_map(lfsr_r);
                        tick_cnt_r      <= 8'd0;
                        display_phase_r <= 1'b1;
                        state_r         <= SHOW;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHOW: begin
                    if (tick) begin
                        if (tick_cnt_r == SHOW_LAST) begin
                            user_input_r    <= 16'd0;
                            digit_cnt_r     <= 3'd0;
                            display_phase_r <= 1'b0;
                            state_r         <= ENTRY;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + 8'd1;
                        end
                    end else begin
                        state_r <= SHOW;
                    end
                end
                ENTRY: begin
                    if (clearBtn) begin
                        user_input_r <= 16'd0;
                        digit_cnt_r  <= 3'd0;
                    end else if (enterBtn && digit_ok_s) begin
                        user_input_r <= next_digits_s;
                        if (digit_cnt_r == 3'd3) begin
                            digit_cnt_r   <= 3'd0;
                            correct_r     <= match_s;
                            streak_r      <= match_s ? sat_inc(streak_r) : 8'd0;
                            tick_cnt_r    <= 8'd0;
                            input_ready_r <= 1'b1;
                            state_r       <= RESULT;
                        end else begin
                            digit_cnt_r <= digit_cnt_r + 3'd1;
                        end
                    end else begin
                        state_r <= ENTRY;
                    end
                end
                RESULT: begin
                    // A restart beats the final tick so a quick player never lands in IDLE.
                    if (startBtn) begin
                        rand_int_r      <= bcd_map(lfsr_r);
                        tick_cnt_r      <= 8'd0;
                        display_phase_r <= 1'b1;
                        input_ready_r   <= 1'b0;
                        state_r         <= SHOW;
                    end else if (tick) begin
                        if (tick_cnt_r == RESULT_LAST) begin
                            input_ready_r <= 1'b0;
                            state_r       <= IDLE;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + 8'd1;
                        end
                    end else begin
                        state_r <= RESULT;
                    end
                end
                default: begin
                    display_phase_r <= 1'b0;
                    input_ready_r   <= 1'b0;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

    assign displayPhase = display_phase_r;
    assign randInt      = rand_int_r;
    assign userInput    = user_input_r;
    assign inputReady   = input_ready_r;
    assign correct      = correct_r;
    assign streak       = streak_r;

endmodule
